// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and a
// multi-cycle freeze for each data-memory access, plus a stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MEM_WAIT_CYCLES = 2,
  parameter int unsigned RA_W            = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_uses_rt,
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_rt,
  input  logic            branch_taken,
  input  logic            dmem_req,
  output logic            pc_write,
  output logic            if_id_write,
  output logic            if_id_flush,
  output logic            id_ex_bubble,
  output logic            freeze,
  output logic [1:0]      state,
  output logic [15:0]     stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    RELEASE  = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LOAD = 8'(MEM_WAIT_CYCLES - 1);

  state_t     cur;
  logic [7:0] cnt;
  logic       load_use;
  logic       mem_start;
  logic       frz;

  assign state = cur;

  always_comb begin
    load_use  = ex_mem_read && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    mem_start = (cur == RUN) && dmem_req;
    frz       = mem_start || (cur == MEM_WAIT);
  end

  // Reset wins over everything; then freeze, load-use bubble, branch flush.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    freeze       = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (frz) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      freeze      = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
    end
  end

  // The request cycle itself is the first frozen cycle, so MEM_WAIT only
  // covers the remaining MEM_WAIT_CYCLES-1 cycles before RELEASE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur          <= RUN;
      cnt          <= '0;
      stall_cycles <= '0;
    end else begin
      case (cur)
        RUN: begin
          if (mem_start) begin
            if (MEM_WAIT_CYCLES > 1) begin
              cur <= MEM_WAIT;
              cnt <= WAIT_LOAD;
            end else begin
              cur <= RELEASE;
            end
          end
        end
        MEM_WAIT: begin
          if (cnt == 8'd1) cur <= RELEASE;
          cnt <= cnt - 8'd1;
        end
        RELEASE: cur <= RUN;
        default: cur <= RUN;
      endcase
      if (!pc_write && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized self-checking bench for hazard_ctrl against a position-in-access
// reference model, with directed load-use, branch, reset and saturation cases.
module tb_hazard_ctrl;
  localparam int N    = 3;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [RA_W-1:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic            id_uses_rt = 1'b0, ex_mem_read = 1'b0;
  logic            branch_taken = 1'b0, dmem_req = 1'b0;
  logic            pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze;
  logic [1:0]      state;
  logic [15:0]     stall_cycles;

  int tests = 0;
  int fails = 0;

  // Model: pos = -1 idle, 0..N-1 frozen cycles of an access, N = release cycle.
  int pos = -1;
  int stall_model = 0;
  int seen_states[$];

  hazard_ctrl #(.MEM_WAIT_CYCLES(N), .RA_W(RA_W)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .freeze(freeze), .state(state),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] ctrlVec();
    return {pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze};
  endfunction

  // One clock cycle: drive, check combinational outputs mid-cycle, clock, advance model.
  task automatic applyStimulus(input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt,
                               input logic urt, input logic emr, input logic [RA_W-1:0] ert,
                               input logic br, input logic dm);
    int cur_pos;
    logic lu, frz;
    logic [4:0] exp_ctrl;
    int exp_state;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = emr;
    ex_rt = ert; branch_taken = br; dmem_req = dm;
    #2;
    cur_pos = (pos < 0 && dm) ? 0 : pos;
    frz = (cur_pos >= 0) && (cur_pos < N);
    lu = emr && (ert != 0) && ((ert == rs) || (urt && ert == rt));
    if (frz)     exp_ctrl = 5'b00001;
    else if (lu) exp_ctrl = 5'b00010;
    else if (br) exp_ctrl = 5'b11100;
    else         exp_ctrl = 5'b11000;
    if (cur_pos <= 0)     exp_state = 0;
    else if (cur_pos < N) exp_state = 1;
    else                  exp_state = 2;
    checkOutput("ctrl", {27'd0, ctrlVec()}, {27'd0, exp_ctrl});
    checkOutput("state", {30'd0, state}, exp_state);
    checkOutput("stall_cycles", {16'd0, stall_cycles}, stall_model);
    seen_states.push_back(state);
    @(posedge clk);
    if (cur_pos < 0 || cur_pos == N) pos = -1;
    else pos = cur_pos + 1;
    if (!exp_ctrl[4] && stall_model < 65535) stall_model++;
    #1;
  endtask

  task automatic idle(); applyStimulus(0, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    // Reset state
    #1 reset = 1'b1;
    #3;
    checkOutput("reset_ctrl", {27'd0, ctrlVec()}, 32'b00110);
    checkOutput("reset_state", {30'd0, state}, 0);
    checkOutput("reset_stall", {16'd0, stall_cycles}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Load-use on rs
    applyStimulus(5, 0, 0, 1, 5, 0, 0);
    checkOutput("lu_stall_inc", {16'd0, stall_cycles}, 1);
    // ex_rt==0 match and rt-only match without id_uses_rt: no stall
    applyStimulus(0, 0, 1, 1, 0, 0, 0);
    applyStimulus(1, 7, 0, 1, 7, 0, 0);
    applyStimulus(1, 7, 1, 1, 7, 0, 0);

    // dmem_req held: states 0,1,1,2,0 and exactly N freeze cycles
    seen_states.delete();
    repeat (N + 1) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    idle();
    checkOutput("seq0", seen_states[0], 0);
    checkOutput("seq1", seen_states[1], 1);
    checkOutput("seq2", seen_states[2], 1);
    checkOutput("seq3", seen_states[3], 2);
    checkOutput("seq4", seen_states[4], 0);

    // Branch with load-use: bubble only, then flush next cycle
    applyStimulus(3, 0, 0, 1, 3, 1, 0);
    checkOutput("br_lu_noflush_seen", {31'd0, if_id_flush}, 0);
    applyStimulus(3, 0, 0, 0, 3, 1, 0);

    // Reset in the middle of MEM_WAIT acts immediately
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("in_mem_wait", {30'd0, state}, 1);
    reset = 1'b1;
    #1;
    checkOutput("async_state", {30'd0, state}, 0);
    checkOutput("async_freeze", {31'd0, freeze}, 0);
    checkOutput("async_stall", {16'd0, stall_cycles}, 0);
    pos = -1; stall_model = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    idle();

    // Random traffic
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                    1'($urandom), $urandom_range(0, 3), 1'($urandom),
                    $urandom_range(0, 3) == 0);

    // Saturation of the stall counter
    repeat (65600) applyStimulus(2, 0, 0, 1, 2, 0, 0);
    checkOutput("stall_saturated", {16'd0, stall_cycles}, 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_WAIT_CYCLES, default 2: total cycles the pipeline freezes per data-memory access; legal range 1..255.
REQ-002 Parameter RA_W, default 5: register-address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 id_rs  input  RA_W  rs field of the instruction held in IF/ID.
REQ-006 id_rt  input  RA_W  rt field of the instruction held in IF/ID.
REQ-007 id_uses_rt  input  1  the IF/ID instruction reads rt.
REQ-008 ex_mem_read  input  1  the ID/EX instruction is a load.
REQ-009 ex_rt  input  RA_W  destination of the ID/EX load.
REQ-010 branch_taken  input  1  taken branch or jump resolved in ID.
REQ-011 dmem_req  input  1  the MEM-stage instruction accesses data memory.
REQ-012 pc_write  output  1  PC load enable.
REQ-013 if_id_write  output  1  IF/ID load enable (1 = capture, 0 = hold).
REQ-014 if_id_flush  output  1  zeroes IF/ID contents at the next edge.
REQ-015 id_ex_bubble  output  1  loads a NOP into ID/EX.
REQ-016 freeze  output  1  holds ID/EX, EX/MEM and MEM/WB.
REQ-017 state  output  2  FSM state: RUN=0, MEM_WAIT=1, RELEASE=2.
REQ-018 stall_cycles  output  16  saturating count of cycles with pc_write=0.

Function
REQ-019 load_use SHALL equal ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & (ex_rt==id_rt))).
REQ-020 mem_start SHALL equal dmem_req in RUN and 0 in every other state.
REQ-021 Output priority SHALL be: mem_start or state MEM_WAIT, then load_use, then branch_taken, then normal.
REQ-022 Freeze case: freeze=1, pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0.
REQ-023 Load-use case (no freeze): pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0; exactly one bubble per hazard, with no internal state.
REQ-024 Branch case (no freeze, no load_use): pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=0.
REQ-025 Normal case: pc_write=1, if_id_write=1, all other control outputs 0.
REQ-026 Outputs SHALL be combinational from state, reset and inputs; a branch suppressed by a stall is re-evaluated next cycle.
REQ-027 RUN transitions: mem_start with MEM_WAIT_CYCLES>1 goes to MEM_WAIT and loads cnt=MEM_WAIT_CYCLES-1; mem_start with MEM_WAIT_CYCLES=1 goes to RELEASE; otherwise remain in RUN.
REQ-028 MEM_WAIT: cnt decrements each cycle; at cnt==1, next state is RELEASE; dmem_req is ignored.
REQ-029 RELEASE lasts exactly one cycle, ignores dmem_req (same held access), applies load_use/branch rules, then returns to RUN.
REQ-030 Freeze SHALL last exactly MEM_WAIT_CYCLES consecutive cycles per access, starting in the request cycle.
REQ-031 stall_cycles SHALL increment on each edge where pc_write=0 and reset=0, saturating at 16'hFFFF.

Reset
REQ-032 reset=1 SHALL immediately force state=RUN, cnt=0, stall_cycles=0, from any state including mid-MEM_WAIT.
REQ-033 While reset=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, freeze=0.
REQ-034 After deassertion, the first edge SHALL operate as RUN with no pending freeze.

Verification
REQ-035 Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; stall_cycles +1.
REQ-036 ex_rt=0 with match, or id_uses_rt=0 with only an rt match -> no stall, normal outputs.
REQ-037 dmem_req held high, MEM_WAIT_CYCLES=3 -> freeze=1 for exactly 3 cycles, state 0,1,1,2,0; no retrigger in RELEASE.
REQ-038 branch_taken with load_use the same cycle -> bubble only, flush=0; next cycle with no hazard -> if_id_flush=1.
REQ-039 Reset asserted during MEM_WAIT -> state=0 and freeze=0 without waiting for a clock edge; stall_cycles=0.
REQ-040 Force 65536+ stall cycles -> stall_cycles holds at 16'hFFFF.
